// File: rtl/mpu_sequencer.sv
// Fetch/execute sequencer: owns the instruction pointer, stalls on host-memory reads and user irqs,
// and emits one commit pulse per instruction. Optional macro MPU_SEQ_SINGLE_STEP_EN adds a step input.
module mpu_sequencer #(
    parameter int unsigned IP_W       = 16,
    parameter int unsigned INSN_W     = 48,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned HM_TIMEOUT = 255
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
`ifdef MPU_SEQ_SINGLE_STEP_EN
    input  logic              step,
`endif
    input  logic              en,
    output logic [IP_W-1:0]   i_addr,
    input  logic [INSN_W-1:0] i_data,
    output logic [INSN_W-1:0] insn,
    output logic              insn_valid,
    input  logic [IP_W-1:0]   ex_isize,
    input  logic              ex_ip_load,
    input  logic [IP_W-1:0]   ex_ip_data,
    input  logic              ex_hm_req,
    input  logic [DATA_W-1:0] ex_hm_addr,
    input  logic              ex_irq_req,
    input  logic [DATA_W-1:0] ex_irq_data,
    output logic [DATA_W-1:0] hm_addr,
    output logic              hm_start,
    input  logic              hm_ack,
    input  logic [DATA_W-1:0] hm_data,
    output logic [DATA_W-1:0] hm_rdata,
    output logic              user_irq,
    output logic [DATA_W-1:0] user_data,
    input  logic              user_ack,
    output logic              commit,
    output logic              halted,
    output logic              hm_err
);

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StFetch   = 3'd1;
    localparam logic [2:0] StExec    = 3'd2;
    localparam logic [2:0] StHmWait  = 3'd3;
    localparam logic [2:0] StIrqWait = 3'd4;
    localparam logic [2:0] StCommit  = 3'd5;
    localparam logic [2:0] StHalt    = 3'd6;

    localparam int unsigned CntW = (HM_TIMEOUT < 2) ? 1 : $clog2(HM_TIMEOUT + 1);

    logic [2:0]        state_q, state_d;
    logic [IP_W-1:0]   ip_q, ip_d, ip_next;
    logic [INSN_W-1:0] insn_q, insn_d;
    logic [DATA_W-1:0] hm_addr_q, hm_addr_d;
    logic [DATA_W-1:0] hm_rdata_q, hm_rdata_d;
    logic [DATA_W-1:0] user_data_q, user_data_d;
    logic [CntW-1:0]   hm_cnt_q, hm_cnt_d;
    logic              hm_err_q, hm_err_d;
    logic              commit_c;
    logic              go;
    logic              hm_expired;

`ifdef MPU_SEQ_SINGLE_STEP_EN
    assign go = en | step;
`else
    assign go = en;
`endif

    // Terminal wait cycle; an ack in this same cycle still takes priority.
    assign hm_expired = (HM_TIMEOUT != 0) && (hm_cnt_q == CntW'(HM_TIMEOUT - 1));

    assign ip_next = ex_ip_load ? ex_ip_data : ip_q + ex_isize;

    always_comb begin
        state_d     = state_q;
        ip_d        = ip_q;
        insn_d      = insn_q;
        hm_addr_d   = hm_addr_q;
        hm_rdata_d  = hm_rdata_q;
        user_data_d = user_data_q;
        hm_cnt_d    = '0;
        hm_err_d    = hm_err_q;
        commit_c    = 1'b0;
        case (state_q)
            StIdle: begin
                if (go) state_d = StFetch;
            end
            StFetch: begin
                state_d = StExec;
            end
            StExec: begin
                insn_d = i_data;
                if (ex_hm_req) begin
                    hm_addr_d = ex_hm_addr;
                    state_d   = StHmWait;
                end else if (ex_irq_req) begin
                    user_data_d = ex_irq_data;
                    state_d     = StIrqWait;
                end else begin
                    commit_c = 1'b1;
                    ip_d     = ip_next;
                    state_d  = en ? StFetch : StIdle;
                end
            end
            StHmWait: begin
                hm_addr_d = ex_hm_addr;
                if (hm_ack) begin
                    hm_rdata_d = hm_data;
                    if (ex_irq_req) begin
                        user_data_d = ex_irq_data;
                        state_d     = StIrqWait;
                    end else begin
                        state_d = StCommit;
                    end
                end else if (hm_expired) begin
                    hm_err_d = 1'b1;
                    state_d  = StHalt;
                end else begin
                    hm_cnt_d = hm_cnt_q + 1'b1;
                end
            end
            StIrqWait: begin
                user_data_d = ex_irq_data;
                if (user_ack) state_d = StCommit;
            end
            StCommit: begin
                commit_c = 1'b1;
                ip_d     = ip_next;
                state_d  = en ? StFetch : StIdle;
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q     <= StIdle;
            ip_q        <= '0;
            insn_q      <= '0;
            hm_addr_q   <= '0;
            hm_rdata_q  <= '0;
            user_data_q <= '0;
            hm_cnt_q    <= '0;
            hm_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ip_q        <= ip_d;
            insn_q      <= insn_d;
            hm_addr_q   <= hm_addr_d;
            hm_rdata_q  <= hm_rdata_d;
            user_data_q <= user_data_d;
            hm_cnt_q    <= hm_cnt_d;
            hm_err_q    <= hm_err_d;
        end
    end

    // The fetched word arrives during EXEC; pass it through then, hold the latched copy afterwards.
    assign insn       = (state_q == StExec) ? i_data : insn_q;
    assign insn_valid = (state_q == StExec) || (state_q == StHmWait) ||
                        (state_q == StIrqWait) || (state_q == StCommit);
    assign i_addr     = ip_q;
    assign hm_addr    = hm_addr_q;
    assign hm_start   = (state_q == StHmWait);
    assign hm_rdata   = hm_rdata_q;
    assign user_irq   = (state_q == StIrqWait);
    assign user_data  = user_data_q;
    assign commit     = commit_c;
    assign halted     = (state_q == StHalt);
    assign hm_err     = hm_err_q;

endmodule

// File: tb/tb_mpu_sequencer.sv
// Directed bench for mpu_sequencer: commits are scoreboarded against an expected queue of
// (instruction address, instruction word) built from a small ip model.
module tb_mpu_sequencer;

    logic        clk = 1'b0;
    logic        sys_rst = 1'b0;
    logic        en = 1'b0;
`ifdef MPU_SEQ_SINGLE_STEP_EN
    logic        step = 1'b0;
`endif
    logic [15:0] i_addr;
    logic [47:0] i_data = '0;
    logic [47:0] insn;
    logic        insn_valid;
    logic [15:0] ex_isize = '0;
    logic        ex_ip_load = 1'b0;
    logic [15:0] ex_ip_data = '0;
    logic        ex_hm_req = 1'b0;
    logic [63:0] ex_hm_addr = '0;
    logic        ex_irq_req = 1'b0;
    logic [63:0] ex_irq_data = '0;
    logic [63:0] hm_addr;
    logic        hm_start;
    logic        hm_ack = 1'b0;
    logic [63:0] hm_data = '0;
    logic [63:0] hm_rdata;
    logic        user_irq;
    logic [63:0] user_data;
    logic        user_ack = 1'b0;
    logic        commit;
    logic        halted;
    logic        hm_err;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [15:0] addr;
        logic [47:0] word;
    } exp_t;
    exp_t        exp_q[$];
    logic [15:0] ip_m = '0;

    mpu_sequencer #(
        .IP_W(16), .INSN_W(48), .DATA_W(64), .HM_TIMEOUT(8)
    ) dut (
        .sys_clk(clk), .sys_rst(sys_rst),
`ifdef MPU_SEQ_SINGLE_STEP_EN
        .step(step),
`endif
        .en(en), .i_addr(i_addr), .i_data(i_data), .insn(insn), .insn_valid(insn_valid),
        .ex_isize(ex_isize), .ex_ip_load(ex_ip_load), .ex_ip_data(ex_ip_data),
        .ex_hm_req(ex_hm_req), .ex_hm_addr(ex_hm_addr), .ex_irq_req(ex_irq_req),
        .ex_irq_data(ex_irq_data), .hm_addr(hm_addr), .hm_start(hm_start), .hm_ack(hm_ack),
        .hm_data(hm_data), .hm_rdata(hm_rdata), .user_irq(user_irq), .user_data(user_data),
        .user_ack(user_ack), .commit(commit), .halted(halted), .hm_err(hm_err)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory: word encodes its own address.
    always @(posedge clk) i_data <= {32'hC0DE_F00D, i_addr};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expect one retirement of the instruction at ip_m, then advance the model.
    task automatic push_insn();
        exp_t e;
        e.addr = ip_m;
        e.word = {32'hC0DE_F00D, ip_m};
        exp_q.push_back(e);
        ip_m = ex_ip_load ? ex_ip_data : ip_m + ex_isize;
    endtask

    always @(negedge clk) begin
        if (commit) begin
            if (exp_q.size() == 0) begin
                check("unexpected_commit", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("commit_addr", i_addr, e.addr);
                check("commit_insn", insn, e.word);
                check("commit_valid", insn_valid, 1);
            end
        end
    end

    // Caller is at a negedge in IDLE; runs one plain instruction and returns in IDLE.
    task automatic run_one(input string tag);
        int c;
        push_insn();
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        c = 0;
        while (!commit && c < 40) begin
            @(negedge clk);
            c++;
        end
        check({tag, "_commit"}, commit, 1);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, u, c, ncom, first, last;

        // Reset state
        @(negedge clk);
        check("rst_i_addr", i_addr, 0);
        check("rst_insn", insn, 0);
        check("rst_insn_valid", insn_valid, 0);
        check("rst_hm_start", hm_start, 0);
        check("rst_user_irq", user_irq, 0);
        check("rst_hm_addr", hm_addr, 0);
        check("rst_user_data", user_data, 0);
        check("rst_hm_rdata", hm_rdata, 0);
        check("rst_halted", halted, 0);
        check("rst_hm_err", hm_err, 0);
        sys_rst = 1'b1;
        @(negedge clk);
        check("idle_no_commit", commit, 0);

        // Three plain instructions back to back
        ex_isize = 16'd6;
        push_insn(); push_insn(); push_insn();
        en = 1'b1;
        ncom = 0; first = 0; last = 0;
        for (int k = 1; k <= 12 && ncom < 3; k++) begin
            @(negedge clk);
            if (commit) begin
                ncom++;
                if (ncom == 1) first = k;
                last = k;
                if (ncom == 3) en = 1'b0;
            end
        end
        check("plain_commits", ncom, 3);
        check("plain_first_cycle", first, 2);
        check("plain_span", last - first, 4);
        @(negedge clk);
        check("plain_ip", i_addr, 16'd18);
        check("plain_idle_valid", insn_valid, 0);

        // Host read, ack in 5th wait cycle, en dropped mid-wait
        ex_isize = 16'd4; ex_hm_req = 1'b1; ex_hm_addr = 64'h1000;
        push_insn();
        en = 1'b1;
        n = 0; c = 0;
        while (!commit && c < 40) begin
            @(negedge clk);
            c++;
            if (hm_start) begin
                n++;
                if (n == 1) begin
                    check("hm_addr", hm_addr, 64'h1000);
                    check("hm_insn_stable", insn, {32'hC0DE_F00D, 16'd18});
                end
                if (n == 2) en = 1'b0;
                if (n == 5) begin
                    hm_ack = 1'b1;
                    hm_data = 64'hDEAD_BEEF;
                end
            end
        end
        hm_ack = 1'b0;
        check("hm_commit", commit, 1);
        check("hm_start_cycles", n, 5);
        check("hm_start_low_at_commit", hm_start, 0);
        check("hm_rdata", hm_rdata, 64'hDEAD_BEEF);
        repeat (3) @(negedge clk);
        check("hm_ip_held", i_addr, 16'd22);

        // Host read followed by user irq, one commit
        ex_isize = 16'd6; ex_irq_req = 1'b1; ex_irq_data = 64'h42;
        push_insn();
        en = 1'b1;
        n = 0; u = 0; c = 0;
        while (!commit && c < 40) begin
            @(negedge clk);
            c++;
            if (c == 1) en = 1'b0;
            if (hm_start) begin
                n++;
                if (n == 2) begin
                    hm_ack = 1'b1;
                    hm_data = 64'h1234;
                end
            end else begin
                hm_ack = 1'b0;
            end
            if (user_irq) begin
                u++;
                if (u == 1) begin
                    check("irq_user_data", user_data, 64'h42);
                    check("irq_hm_start_low", hm_start, 0);
                end
                if (u == 3) user_ack = 1'b1;
            end
        end
        user_ack = 1'b0;
        check("irq_commit", commit, 1);
        check("irq_cycles", u, 3);
        check("irq_low_at_commit", user_irq, 0);
        check("irq_hm_rdata", hm_rdata, 64'h1234);
        ex_hm_req = 1'b0; ex_irq_req = 1'b0;
        @(negedge clk);
        check("irq_ip", i_addr, 16'd28);

        // Branch, wrap-around and branch again
        ex_ip_load = 1'b1; ex_ip_data = 16'hFFFC;
        run_one("br_fffc");
        check("br_fffc_ip", i_addr, 16'hFFFC);
        ex_ip_load = 1'b0; ex_isize = 16'd6;
        run_one("wrap");
        check("wrap_ip", i_addr, 16'h0002);
        ex_ip_load = 1'b1; ex_ip_data = 16'h0100;
        run_one("br_100");
        check("br_100_ip", i_addr, 16'h0100);
        ex_ip_load = 1'b0;

        // Ack on the terminal wait cycle beats the timeout
        ex_isize = 16'd2; ex_hm_req = 1'b1; ex_hm_addr = 64'h2000;
        push_insn();
        en = 1'b1;
        n = 0; c = 0;
        while (!commit && c < 40) begin
            @(negedge clk);
            c++;
            if (c == 1) en = 1'b0;
            if (hm_start) begin
                n++;
                if (n == 8) begin
                    hm_ack = 1'b1;
                    hm_data = 64'hCAFE;
                end
            end
        end
        hm_ack = 1'b0;
        check("term_commit", commit, 1);
        check("term_cycles", n, 8);
        check("term_not_halted", halted, 0);
        check("term_hm_err", hm_err, 0);
        check("term_hm_rdata", hm_rdata, 64'hCAFE);
        ex_hm_req = 1'b0;
        @(negedge clk);
        check("term_ip", i_addr, 16'h0102);

`ifdef MPU_SEQ_SINGLE_STEP_EN
        // Single step with en low runs exactly one instruction
        push_insn();
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        c = 0;
        while (!commit && c < 20) begin
            @(negedge clk);
            c++;
        end
        check("step_commit", commit, 1);
        repeat (4) @(negedge clk);
        check("step_ip", i_addr, ip_m);
`endif

        // Timeout: no ack, halt with sticky error and no commit
        ex_hm_req = 1'b1; ex_hm_addr = 64'h3000;
        en = 1'b1;
        n = 0; c = 0;
        while (!halted && c < 40) begin
            @(negedge clk);
            c++;
            if (c == 1) en = 1'b0;
            if (hm_start) n++;
        end
        check("to_halted", halted, 1);
        check("to_hm_err", hm_err, 1);
        check("to_cycles", n, 8);
        check("to_hm_start_low", hm_start, 0);
        en = 1'b1;
        repeat (4) @(negedge clk);
        check("to_still_halted", halted, 1);
        check("to_start_still_low", hm_start, 0);
        en = 1'b0;
        sys_rst = 1'b0;
        #1;
        check("to_rst_halted", halted, 0);
        check("to_rst_hm_err", hm_err, 0);
        check("to_rst_ip", i_addr, 0);
        @(negedge clk);
        sys_rst = 1'b1;
        ip_m = '0;

        // Reset in the middle of a host handshake
        en = 1'b1;
        n = 0; c = 0;
        while (n < 3 && c < 40) begin
            @(negedge clk);
            c++;
            if (c == 1) en = 1'b0;
            if (hm_start) n++;
        end
        check("mid_reached_wait", n, 3);
        sys_rst = 1'b0;
        #1;
        check("mid_hm_start_drop", hm_start, 0);
        check("mid_no_commit", commit, 0);
        @(negedge clk);
        sys_rst = 1'b1;
        ex_hm_req = 1'b0;
        @(negedge clk);

        // Recovery after reset
        ex_isize = 16'd6;
        run_one("recover");
        check("recover_ip", i_addr, 16'd6);
        check("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
